// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM channel loader: register map, FSM states,
// the buffered command record and the register-write table.
package pcm_pkg;

  localparam logic [9:0] REG_TYPE_BASE = 10'h200;
  localparam logic [9:0] REG_KEY_ON    = 10'h214;
  localparam logic [9:0] REG_KEY_OFF   = 10'h215;
  localparam logic [9:0] REG_MASTER    = 10'h22F;
  localparam logic [9:0] CH_STRIDE     = 10'h020;
  localparam int         REGS_WRITES   = 15;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_KOFF,
    ST_REGS,
    ST_KON,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [2:0]  ch;
    logic [23:0] pitch;
    logic [7:0]  vol;
    logic [7:0]  rev_vol;
    logic [15:0] rev_dly;
    logic [23:0] loop_addr;
    logic [23:0] start_addr;
    logic [7:0]  wave_type;
    logic        loopen;
    logic        keyon;
    logic        retrig;
  } cmd_t;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  function automatic logic [9:0] ch_base(logic [2:0] ch);
    return 10'(ch) * CH_STRIDE;
  endfunction

  // Address/data of the idx-th per-channel register write (0..14).
  function automatic wr_t regs_write(cmd_t c, logic [3:0] idx);
    logic [9:0] b;
    wr_t        w;
    b = ch_base(c.ch);
    w = '{addr: b, data: 8'h00};
    case (idx)
      4'd0:  w = '{addr: b + 10'h000, data: c.pitch[7:0]};
      4'd1:  w = '{addr: b + 10'h001, data: c.pitch[15:8]};
      4'd2:  w = '{addr: b + 10'h002, data: c.pitch[23:16]};
      4'd3:  w = '{addr: b + 10'h003, data: c.vol};
      4'd4:  w = '{addr: b + 10'h004, data: c.rev_vol};
      4'd5:  w = '{addr: b + 10'h006, data: c.rev_dly[7:0]};
      4'd6:  w = '{addr: b + 10'h007, data: c.rev_dly[15:8]};
      4'd7:  w = '{addr: b + 10'h008, data: c.loop_addr[7:0]};
      4'd8:  w = '{addr: b + 10'h009, data: c.loop_addr[15:8]};
      4'd9:  w = '{addr: b + 10'h00A, data: c.loop_addr[23:16]};
      4'd10: w = '{addr: b + 10'h00C, data: c.start_addr[7:0]};
      4'd11: w = '{addr: b + 10'h00D, data: c.start_addr[15:8]};
      4'd12: w = '{addr: b + 10'h00E, data: c.start_addr[23:16]};
      4'd13: w = '{addr: REG_TYPE_BASE + {6'b0, c.ch, 1'b0}, data: c.wave_type};
      4'd14: w = '{addr: REG_TYPE_BASE + {6'b0, c.ch, 1'b1}, data: {7'b0, c.loopen}};
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pcm_cmd_fifo.sv
// Command buffer: power-of-two depth FIFO with a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pcm_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write on accepted push.
  // NOTE: the data array is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // Pointer update; push and pop in the same cycle both take effect.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pcm_ch_loader.sv
// PCM channel loader: buffers channel-setup commands and replays each one as
// a paced series of single-cycle CPU register writes (key-off, 15 channel
// registers, key-on). All CPU-side outputs and ERR are registered.
module pcm_ch_loader
  import pcm_pkg::*;
#(
  parameter int CH_COUNT   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_CH,
  input  logic [23:0] CMD_PITCH,
  input  logic [7:0]  CMD_VOL,
  input  logic [7:0]  CMD_REV_VOL,
  input  logic [15:0] CMD_REV_DLY,
  input  logic [23:0] CMD_LOOP,
  input  logic [23:0] CMD_START,
  input  logic [7:0]  CMD_TYPE,
  input  logic        CMD_LOOPEN,
  input  logic        CMD_KEYON,
  input  logic        CMD_RETRIG,
  output logic [9:0]  CPU_ADDR,
  output logic [7:0]  CPU_DATA,
  output logic        CPU_WR,
  output logic        BUSY,
  output logic        ERR
);

  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  cmd_t        cmd_in, head, cur_q, step_cmd_d;
  state_e      state_q, ret_q, step_state_d, next_state_d;
  logic [3:0]  widx_q, step_idx_d, next_idx_d;
  logic [GW-1:0] gap_q;
  logic [9:0]  addr_q;
  logic [7:0]  data_q;
  logic        wr_q, err_q;
  logic        fifo_empty, fifo_full, accept, reject, push, pop, issue_d;
  wr_t         wr_d;

  assign cmd_in = '{ch: CMD_CH, pitch: CMD_PITCH, vol: CMD_VOL, rev_vol: CMD_REV_VOL,
                    rev_dly: CMD_REV_DLY, loop_addr: CMD_LOOP, start_addr: CMD_START,
                    wave_type: CMD_TYPE, loopen: CMD_LOOPEN, keyon: CMD_KEYON,
                    retrig: CMD_RETRIG};

  assign CMD_READY = !fifo_full && (state_q != ST_INIT);
  assign accept    = CMD_VALID && CMD_READY;
  assign reject    = accept && (int'(CMD_CH) >= CH_COUNT);
  assign push      = accept && !reject;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign BUSY      = (state_q != ST_IDLE) || !fifo_empty;

  assign CPU_ADDR = addr_q;
  assign CPU_DATA = data_q;
  assign CPU_WR   = wr_q;
  assign ERR      = err_q;

  pcm_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst_n  (nRESET),
    .push_i (push),
    .din_i  (cmd_in),
    .pop_i  (pop),
    .dout_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Select the write to issue this cycle and the step that follows it. IDLE
  // works on the FIFO head so the first strobe lands right after the pop.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    step_cmd_d   = (state_q == ST_IDLE) ? head : cur_q;
    step_state_d = state_q;
    step_idx_d   = widx_q;
    if (state_q == ST_IDLE) begin
      step_state_d = head.retrig ? ST_KOFF : ST_REGS;
      step_idx_d   = '0;
    end
    issue_d      = 1'b0;
    wr_d         = '0;
    next_state_d = ST_IDLE;
    next_idx_d   = '0;
    case (step_state_d)
      ST_INIT: begin
        issue_d = 1'b1;
        wr_d    = '{addr: REG_MASTER, data: 8'h01};
      end
      ST_KOFF: begin
        issue_d      = 1'b1;
        wr_d         = '{addr: REG_KEY_OFF, data: 8'b1 << step_cmd_d.ch};
        next_state_d = ST_REGS;
      end
      ST_REGS: begin
        issue_d = 1'b1;
        wr_d    = regs_write(step_cmd_d, step_idx_d);
        if (step_idx_d == 4'(REGS_WRITES - 1)) begin
          next_state_d = step_cmd_d.keyon ? ST_KON : ST_IDLE;
        end else begin
          next_state_d = ST_REGS;
          next_idx_d   = step_idx_d + 4'd1;
        end
      end
      ST_KON: begin
        issue_d = 1'b1;
        wr_d    = '{addr: REG_KEY_ON, data: 8'b1 << step_cmd_d.ch};
      end
      default: ;
    endcase
    if ((state_q == ST_IDLE) && fifo_empty) issue_d = 1'b0;
  end

  // Sequencer FSM with registered CPU strobe, address, data and ERR.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q <= ST_INIT;
      ret_q   <= ST_IDLE;
      widx_q  <= '0;
      gap_q   <= '0;
      cur_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q  <= issue_d;
      err_q <= reject;
      if (pop) cur_q <= head;
      if (issue_d) begin
        addr_q <= wr_d.addr;
        data_q <= wr_d.data;
        widx_q <= next_idx_d;
        if (WR_GAP > 0) begin
          state_q <= ST_GAP;
          ret_q   <= next_state_d;
          gap_q   <= GW'(WR_GAP - 1);
        end else begin
          state_q <= next_state_d;
        end
      end else if (state_q == ST_GAP) begin
        if (gap_q == '0) state_q <= ret_q;
        else             gap_q   <= gap_q - GW'(1);
      end
    end
  end

endmodule

// File: doc/pcm_ch_loader.md
PCM_CH_LOADER -- requirements
Module: pcm_ch_loader

Interface
REQ-001 SHALL have parameter CH_COUNT, default 8, number of addressable PCM channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command buffer entries (power of two, >=2).
REQ-003 SHALL have parameter WR_GAP, default 1, idle cycles between successive CPU_WR pulses (>=0).
REQ-004 SHALL have ports: CLK  in  1  sole clock; nRESET  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: CMD_VALID in 1 command offer; CMD_READY out 1 command accept; CMD_CH in 3 channel index.
REQ-006 SHALL have ports: CMD_PITCH in 24; CMD_VOL in 8; CMD_REV_VOL in 8; CMD_REV_DLY in 16; CMD_LOOP in 24 loop start; CMD_START in 24 start address.
REQ-007 SHALL have ports: CMD_TYPE in 8; CMD_LOOPEN in 1; CMD_KEYON in 1 key-on after load; CMD_RETRIG in 1 key-off before load.
REQ-008 SHALL have ports: CPU_ADDR out 10; CPU_DATA out 8; CPU_WR out 1 write strobe; BUSY out 1; ERR out 1 one-cycle reject pulse.

Function
REQ-009 SHALL accept a command on any rising CLK where CMD_VALID and CMD_READY are both 1, storing all CMD_* fields in the FIFO.
REQ-010 SHALL drive CMD_READY = 1 iff FIFO not full and not in INIT; a VALID while READY=0 is neither stored nor flagged.
REQ-011 SHALL reject (not store) a command with CMD_CH >= CH_COUNT and pulse ERR for exactly the acceptance cycle.
REQ-012 SHALL implement states INIT, IDLE, KOFF, REGS, KON, GAP.
REQ-013 INIT: first cycle after reset release SHALL write ADDR 0x22F DATA 0x01, then go to IDLE.
REQ-014 IDLE: FIFO non-empty SHALL pop head and enter KOFF if RETRIG=1, else REGS; first write strobe occurs in the cycle after pop.
REQ-015 KOFF: SHALL write ADDR 0x215 DATA (1<<CH).
REQ-016 REGS: SHALL issue 15 writes in order, base B=CH*0x20: B+0x00..0x02 pitch LSB..MSB, B+0x03 VOL, B+0x04 REV_VOL, B+0x06/0x07 REV_DLY LSB/MSB, B+0x08..0x0A LOOP LSB..MSB, B+0x0C..0x0E START LSB..MSB, 0x200+2*CH TYPE, 0x201+2*CH {7'b0,LOOPEN}.
REQ-017 KON: if KEYON=1 SHALL write ADDR 0x214 DATA (1<<CH); else skipped.
REQ-018 Every write SHALL be a single-cycle CPU_WR=1 with ADDR/DATA valid that cycle, followed by exactly WR_GAP cycles of CPU_WR=0 (GAP state); ADDR/DATA hold their last values while CPU_WR=0.
REQ-019 After the last write of a command, SHALL return to IDLE and pop the next entry with no extra gap beyond WR_GAP.
REQ-020 BUSY SHALL be 1 in INIT, KOFF, REGS, KON, GAP, or when FIFO non-empty; 0 otherwise.
REQ-021 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-022 Write-index counter SHALL be 4 bits, reset to 0 on each REGS entry; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-023 nRESET=0 at a rising edge SHALL set CPU_ADDR=0, CPU_DATA=0, CPU_WR=0, ERR=0, CMD_READY=0, BUSY=1, FIFO empty, state INIT.
REQ-024 Reset asserted mid-sequence SHALL abort it with no further writes; buffered commands discarded; INIT reruns after release.

Structure
REQ-025 Register offsets (0x200, 0x214, 0x215, 0x22F, channel stride 0x20), state enumeration and command record type SHALL live in a shared package pcm_pkg.
REQ-026 The command buffer SHALL be one sub-module, pcm_cmd_fifo, parametrised by width and FIFO_DEPTH.

Verification
REQ-027 Reset release, no command -> single write 0x22F=0x01 next cycle, then BUSY=0, CPU_WR idle.
REQ-028 CH=0, PITCH=0x000015, VOL=0x30, REV_VOL=0x10, REV_DLY=0x0123, LOOP=0x001000, START=0x00002A, TYPE=0, LOOPEN=0, KEYON=1, WR_GAP=1 -> 16 writes 000=15..00E=00, 200=00, 201=00, 214=01, pulses spaced 2 cycles.
REQ-029 CH=5, RETRIG=1, KEYON=1 -> first write 215=20, then 0A0..0AE, 20A, 20B, last write 214=20.
REQ-030 Push FIFO_DEPTH commands back-to-back while busy -> READY drops after the last push, rises after first pop; all commands executed in order without loss.
REQ-031 CMD_CH=7 with CH_COUNT=4 -> ERR one cycle, no writes, BUSY unchanged.
REQ-032 nRESET low during 8th REGS write with 2 queued commands -> CPU_WR stays 0, after release only 22F=01 written, BUSY=0.
